// File: rtl/axis_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_rr_arbiter_if
//  Description : Bundle of the NUM_SRC flattened AXI4-Stream slave ports, the
//                single AXI4-Stream master port and the grant status of the
//                round-robin stream arbiter.
//                Flattened buses pack source i at [i*W +: W].
//  Modports    : slave  - arbiter side (consumes S_*, produces M_* / GRANT_*)
//                master - environment side (produces S_*, consumes M_*)
//  Revision    : 1.0  initial release
// ============================================================================
interface axis_rr_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 1
);
    localparam int c_kw    = DATA_WIDTH / 8;
    localparam int c_idx_w = $clog2(NUM_SRC);

    // Upstream (per-source) stream ports
    logic [NUM_SRC-1:0]            S_TVALID;
    logic [NUM_SRC-1:0]            S_TREADY;
    logic [NUM_SRC*DATA_WIDTH-1:0] S_TDATA;
    logic [NUM_SRC*c_kw-1:0]       S_TSTRB;
    logic [NUM_SRC*c_kw-1:0]       S_TKEEP;
    logic [NUM_SRC-1:0]            S_TLAST;
    logic [NUM_SRC*ID_WIDTH-1:0]   S_TID;
    logic [NUM_SRC*DEST_WIDTH-1:0] S_TDEST;
    logic [NUM_SRC*USER_WIDTH-1:0] S_TUSER;

    // Downstream (merged) stream port
    logic                          M_TVALID;
    logic                          M_TREADY;
    logic [DATA_WIDTH-1:0]         M_TDATA;
    logic [c_kw-1:0]               M_TSTRB;
    logic [c_kw-1:0]               M_TKEEP;
    logic                          M_TLAST;
    logic [ID_WIDTH-1:0]           M_TID;
    logic [DEST_WIDTH-1:0]         M_TDEST;
    logic [USER_WIDTH-1:0]         M_TUSER;

    // Grant status
    logic                          GRANT_VALID;
    logic [c_idx_w-1:0]            GRANT_IDX;

    modport slave (
        input  S_TVALID, S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER,
        output S_TREADY,
        output M_TVALID, M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER,
        input  M_TREADY,
        output GRANT_VALID, GRANT_IDX
    );

    modport master (
        output S_TVALID, S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER,
        input  S_TREADY,
        input  M_TVALID, M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER,
        output M_TREADY,
        input  GRANT_VALID, GRANT_IDX
    );
endinterface
`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_rr_arbiter
//  Description : Packet-granular round-robin arbiter merging NUM_SRC
//                AXI4-Stream sources onto one registered AXI4-Stream master.
//                A grant is taken in an IDLE arbitration cycle and held until
//                the granted source's TLAST beat is accepted, so packets are
//                never interleaved.
//  Ports       : ACLK   - clock, rising edge
//                ARESET - asynchronous active-high reset
//                axis   - slave modport of axis_rr_arbiter_if (S_*, M_*,
//                         GRANT_VALID, GRANT_IDX)
//  Revision    : 1.0  initial release
// ============================================================================
module axis_rr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 1
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    axis_rr_arbiter_if.slave     axis
);
    localparam int c_kw    = DATA_WIDTH / 8;
    localparam int c_idx_w = $clog2(NUM_SRC);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_idx_w-1:0]   r_grant_idx;
    logic [c_idx_w-1:0]   w_winner;
    logic [c_idx_w-1:0]   w_ptr_after_grant;
    logic                 w_any_valid;
    logic                 w_out_ready;
    logic                 w_accept;
    logic                 w_accept_last;
    logic [NUM_SRC-1:0]   w_s_tready;
    int                   w_sel;

    logic                  r_m_tvalid;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [c_kw-1:0]       r_m_tstrb;
    logic [c_kw-1:0]       r_m_tkeep;
    logic                  r_m_tlast;
    logic [ID_WIDTH-1:0]   r_m_tid;
    logic [DEST_WIDTH-1:0] r_m_tdest;
    logic [USER_WIDTH-1:0] r_m_tuser;

    assign w_any_valid = |axis.S_TVALID;
    assign w_sel       = int'(r_grant_idx);

    // Circular search from r_rr_ptr upward, wrapping at NUM_SRC-1 (not at
    // the next power of two) so non-power-of-two source counts stay fair.
    always_comb begin
        int   v_idx;
        logic v_found;
        w_winner = '0;
        v_found  = 1'b0;
        v_idx    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_SRC) begin
                v_idx = v_idx - NUM_SRC;
            end
            if (!v_found && axis.S_TVALID[v_idx]) begin
                v_found  = 1'b1;
                w_winner = c_idx_w'(v_idx);
            end
        end
    end

    assign w_ptr_after_grant = (r_grant_idx == c_idx_w'(NUM_SRC - 1)) ? '0
                             : r_grant_idx + c_idx_w'(1);

    // The output register can take a new beat when it is empty or being
    // drained this cycle; this makes S_TREADY combinational on M_TREADY.
    assign w_out_ready = ~r_m_tvalid | axis.M_TREADY;

    always_comb begin
        w_s_tready = '0;
        if (r_state == ST_LOCKED) begin
            w_s_tready[w_sel] = w_out_ready;
        end
    end

    assign w_accept      = (r_state == ST_LOCKED) & axis.S_TVALID[w_sel] & w_out_ready;
    assign w_accept_last = w_accept & axis.S_TLAST[w_sel];

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_accept_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state, grant index and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_any_valid) begin
                r_grant_idx <= w_winner;
            end else if (w_accept_last) begin
                r_grant_idx <= '0;
                r_rr_ptr    <= w_ptr_after_grant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tstrb  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tid    <= '0;
            r_m_tdest  <= '0;
            r_m_tuser  <= '0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= axis.S_TDATA[w_sel*DATA_WIDTH +: DATA_WIDTH];
            r_m_tstrb  <= axis.S_TSTRB[w_sel*c_kw +: c_kw];
            r_m_tkeep  <= axis.S_TKEEP[w_sel*c_kw +: c_kw];
            r_m_tlast  <= axis.S_TLAST[w_sel];
            r_m_tid    <= axis.S_TID[w_sel*ID_WIDTH +: ID_WIDTH];
            r_m_tdest  <= axis.S_TDEST[w_sel*DEST_WIDTH +: DEST_WIDTH];
            r_m_tuser  <= axis.S_TUSER[w_sel*USER_WIDTH +: USER_WIDTH];
        end else if (r_m_tvalid && axis.M_TREADY) begin
            // Fields are left as-is; only the valid flag drops.
            r_m_tvalid <= 1'b0;
        end
    end

    assign axis.S_TREADY    = w_s_tready;
    assign axis.M_TVALID    = r_m_tvalid;
    assign axis.M_TDATA     = r_m_tdata;
    assign axis.M_TSTRB     = r_m_tstrb;
    assign axis.M_TKEEP     = r_m_tkeep;
    assign axis.M_TLAST     = r_m_tlast;
    assign axis.M_TID       = r_m_tid;
    assign axis.M_TDEST     = r_m_tdest;
    assign axis.M_TUSER     = r_m_tuser;
    assign axis.GRANT_VALID = (r_state == ST_LOCKED);
    assign axis.GRANT_IDX   = r_grant_idx;

endmodule
`default_nettype wire

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-granular round-robin arbiter that merges NUM_SRC AXI4-Stream sources onto one AXI4-Stream master port. A grant is held from the first beat of a packet until its TLAST beat is accepted, so packets are never interleaved. The output is a registered pipeline stage. It sits between multiple stream producers, such as several master BFM-driven or DUT-internal sources, and a single shared stream consumer.

## Interface
- NUM_SRC, 4: number of slave (input) ports, 2..16
- DATA_WIDTH, 32: TDATA width in bits, multiple of 8; TKEEP/TSTRB width is DATA_WIDTH/8 (KW)
- ID_WIDTH, 4: TID width
- DEST_WIDTH, 4: TDEST width
- USER_WIDTH, 1: TUSER width
- Clocking and reset: one clock; reset is asynchronous and active-high.
- ACLK  in  1  clock; all logic samples on the rising edge
- ARESET  in  1  asynchronous, active-high reset
- S_TVALID  in  NUM_SRC  per-source valid
- S_TREADY  out  NUM_SRC  per-source ready
- S_TDATA  in  NUM_SRC*DATA_WIDTH  source i at bits [i*DATA_WIDTH +: DATA_WIDTH]; all flattened buses use this packing
- S_TSTRB, S_TKEEP  in  NUM_SRC*KW  byte qualifiers
- S_TLAST  in  NUM_SRC  end of packet
- S_TID  in  NUM_SRC*ID_WIDTH; S_TDEST  in  NUM_SRC*DEST_WIDTH; S_TUSER  in  NUM_SRC*USER_WIDTH
- M_TVALID  out  1; M_TREADY  in  1
- M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER  out  single-port widths as above
- GRANT_VALID  out  1  a source currently holds the grant
- GRANT_IDX  out  $clog2(NUM_SRC)  index of the granted source; 0 when GRANT_VALID=0

## Operation
- FSM states:
  - IDLE: no grant; all S_TREADY=0.
  - LOCKED: one source is granted.
- IDLE → LOCKED when any S_TVALID=1 at the clock edge.
  - Winner: the first set bit of S_TVALID, searching circularly from rr_ptr upward (rr_ptr, rr_ptr+1, … wrapping at NUM_SRC-1 → 0).
  - GRANT_IDX is registered with the winner; GRANT_VALID=1.
- In LOCKED, S_TREADY[GRANT_IDX] = ~M_TVALID | M_TREADY. All other S_TREADY bits are 0.
  - This is a combinational path from M_TREADY; it is allowed.
- A beat is accepted when S_TVALID[g] & S_TREADY[g]. On acceptance, all source fields of g load into the output register and M_TVALID is set to 1.
- Output register:
  - If M_TVALID & M_TREADY and no new beat is accepted in the same cycle, M_TVALID clears to 0.
  - Simultaneous output handshake and input acceptance: the register reloads and M_TVALID stays 1.
  - While M_TVALID=1 & M_TREADY=0, output fields hold stable. This is the AXIS hold rule; the bench checks it.
- LOCKED → IDLE on the edge where a beat with S_TLAST=1 is accepted from g.
  - At that edge, rr_ptr ← (g+1) mod NUM_SRC.
  - GRANT_VALID ← 0 and GRANT_IDX ← 0.
- Granted source drops TVALID mid-packet: the grant is held indefinitely and other sources wait. There is no timeout.
- Non-granted sources are never sampled. Their TVALID may stay high for any duration.
- Field pass-through is unmodified. TID is not rewritten with the source index.

## Timing
- Reset values, applied asynchronously while ARESET=1:
  - State=IDLE, rr_ptr=0.
  - M_TVALID=0; all M_T* data fields 0.
  - S_TREADY=0, GRANT_VALID=0, GRANT_IDX=0.
- Reset mid-packet: the partial packet is discarded (including any beat held in the output register). After release, arbitration restarts from source 0.
- Latency:
  - Arbitration edge at cycle N; the first beat can be accepted at edge N+1; M_TVALID=1 from cycle N+1 after that edge.
  - Accepted beat → M_TVALID is 1 cycle.
- Throughput: 1 beat/cycle within a packet when M_TREADY=1.
- Exactly one idle cycle (IDLE arbitration) occurs between consecutive packets. Max packet rate is L/(L+1) for L-beat packets.
- Single-beat packet (TLAST on first beat): the grant lasts exactly one LOCKED cycle.
- NUM_SRC not a power of two: the circular search and rr_ptr wrap at NUM_SRC-1, never at 2^clog2.

## Test plan
- Reset and single source:
  - Stimulus: hold ARESET 3 cycles; after release, source 2 sends a 4-beat packet, TDATA 0xA0..0xA3, M_TREADY=1.
  - Required response: outputs are 0 during reset; GRANT_IDX=2; M_TDATA shows 0xA0..0xA3 on 4 consecutive cycles, starting 2 cycles after S_TVALID rises; TLAST only on 0xA3.
- Round-robin fairness:
  - Stimulus: all 4 sources continuously offer 2-beat packets.
  - Required response: grant order is 0,1,2,3,0,1…; no interleaving; 1 idle cycle between packets.
- Backpressure:
  - Stimulus: M_TREADY toggles 1,0,0,1 during a 5-beat packet.
  - Required response: M_T* fields stable while stalled; no beat lost or duplicated; S_TREADY[g]=0 when M_TVALID=1 & M_TREADY=0.
- Grant lock with gaps:
  - Stimulus: source 1 granted and deasserts TVALID 3 cycles mid-packet while source 3 is valid.
  - Required response: S_TREADY[3] stays 0; source 3 is granted only after source 1's TLAST is accepted.
- Pointer wrap and reset mid-packet:
  - Stimulus: NUM_SRC=3, sources 2 and 0 valid with rr_ptr=2; then assert ARESET during beat 2 of source 0's packet.
  - Required response: source 2 is granted first and source 0 next; during reset M_TVALID and GRANT_VALID drop immediately; after release, arbitration starts from source 0.
